dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined ARM core: the slave end of the Memory-stage interface driven by the datapath (byte address, store data, read/write strobes). It services each load/store with a programmable number of wait states, holds the pipeline via a stall output, and returns load data. It flags misaligned and out-of-range accesses. It replaces the zero-latency behavioural data memory, so hazard/stall logic can be exercised against realistic memory latency.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words in the array; word index = ALUOutM[31:2].
- WAIT_CYCLES, 2: stall cycles per access, legal range 0..15.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- MemReadM  in  1  load request, level-sensitive.
- MemWriteM  in  1  store request, level-sensitive.
- ALUOutM  in  32  byte address of the access.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data.
- StallM  out  1  high while an access is pending; the pipeline freezes F/D/E/M.
- ErrM  out  1  one-cycle error pulse in the completion cycle.
- ErrSticky  out  1  latched error flag; cleared only by reset.

## Operation
- req = MemReadM | MemWriteM. The access is illegal if both strobes are high, ALUOutM[1:0] != 0, or ALUOutM[31:2] >= DEPTH_WORDS.
- 4-bit wait counter cnt. State IDLE when cnt == 0; state WAIT when 0 < cnt < WAIT_CYCLES.
- IDLE with req high:
  - Capture the type, address and store data into request registers.
  - If WAIT_CYCLES > 0: StallM = 1 and cnt becomes 1.
  - If WAIT_CYCLES = 0: the cycle is the completion cycle.
- WAIT with req high: StallM = 1 and cnt increments. Live inputs are ignored; the captured request is used.
- Completion cycle is when req is high and cnt == WAIT_CYCLES.
  - StallM = 0.
  - The access uses the captured request, or the live inputs when WAIT_CYCLES = 0.
  - cnt returns to 0 at the edge.
- Store: at the completion edge, mem[word] <= data if the access is legal. An illegal store is dropped.
- Load:
  - In the completion cycle, ReadDataM = mem[word] combinationally, or 0 if the access is illegal.
  - ReadDataM is registered into rd_q at the edge. Outside completion cycles, ReadDataM = rd_q (holds the last load).
- Error: ErrM = 1 only in a completion cycle with an illegal access. ErrSticky is set at that edge.
- Abort: if req drops while in WAIT (flush), cnt returns to 0 at the next edge. No write or rd_q update occurs, and no error is raised.
- Back-to-back: a request present in the cycle after a completion is a new access and incurs the full WAIT_CYCLES again.
- The memory array is not reset. Contents are undefined until written.

## Timing
- Reset values: cnt = 0, rd_q = 0, ErrSticky = 0.
- Reset outputs: ReadDataM = 0, StallM = 0, ErrM = 0 (with req low).
- Access latency: WAIT_CYCLES + 1 cycles from the first req cycle to the completion cycle, inclusive. StallM is high for exactly WAIT_CYCLES cycles.
- Stall path: StallM, ErrM and completion-cycle ReadDataM are combinational from the req strobes, ALUOutM and cnt. Everything else is registered.
- Store-to-load forwarding is not needed. A load completing after a store completion edge sees the new data.
- Reset asserted mid-access:
  - cnt, rd_q and ErrSticky clear immediately.
  - The pending store is dropped and StallM drops.
  - After release, a still-asserted req starts a fresh access.
- Counter wrap: cnt never exceeds WAIT_CYCLES, so no wrap occurs. WAIT_CYCLES = 15 uses the full 4-bit range.

## Test plan
- Store then load, WAIT_CYCLES = 2:
  - Stimulus: store 0xDEADBEEF to address 0x10, then load 0x10.
  - Response: each access shows StallM = 1, 1, 0; ReadDataM = 0xDEADBEEF in the load completion cycle and held afterwards; ErrM never pulses.
- Input change mid-wait:
  - Stimulus: store 0x11111111 to 0x20; in the second cycle, change to 0x22222222 at 0x24.
  - Response: a later load of 0x20 returns 0x11111111; a later load of 0x24 returns its prior contents.
- Illegal accesses:
  - Stimulus: store to misaligned 0x13; load from 0x100 (word 64 >= 64); assert both strobes at 0x0.
  - Response: each access completes after 2 stalls with ErrM = 1; the load returns 0; no memory word changes; ErrSticky = 1 thereafter.
- Flush abort:
  - Stimulus: a store to 0x8 drops req after one stall cycle.
  - Response: cnt returns to 0 and mem[2] is unchanged; the next request stalls for 2 full cycles; ErrM = 0.
- Reset mid-access:
  - Stimulus: assert reset during the stall of a store of 0xCAFEF00D to 0x4.
  - Response: StallM = 0, ReadDataM = 0 and ErrSticky = 0 at once; after release with req held, 2 new stalls occur, then the write commits.
- Zero-wait build, WAIT_CYCLES = 0:
  - Stimulus: back-to-back store 0x5 to 0x0 and load 0x0.
  - Response: StallM is always 0; the load returns 0x5 in the same cycle it is presented.

Source files
------------

// File: rtl/dmem_responder.sv
// Memory-stage data memory slave: services each load/store after WAIT_CYCLES
// stall cycles and flags misaligned, out-of-range or dual-strobe accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        ErrM,
    output logic        ErrSticky
);
    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_N    = 4'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [3:0]    cnt;
    logic [31:0]   rd_q;
    logic          cap_rd_p0;
    logic          cap_wr_p0;
    logic [31:0]   cap_addr_p0;
    logic [31:0]   cap_data_p0;
    logic          req;
    logic          done;
    logic          bad;
    logic          acc_rd;
    logic          acc_wr;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_data;
    logic [31:0]   rd_val;
    logic [AW-1:0] idx;

    function automatic logic is_illegal(input logic r, input logic w, input logic [31:0] a);
        return (r && w) || (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    // Stall path: with no wait states the live strobes are the access itself.
    always_comb begin
        req       = MemReadM | MemWriteM;
        acc_rd    = ZERO_WAIT ? MemReadM   : cap_rd_p0;
        acc_wr    = ZERO_WAIT ? MemWriteM  : cap_wr_p0;
        acc_addr  = ZERO_WAIT ? ALUOutM    : cap_addr_p0;
        acc_data  = ZERO_WAIT ? WriteDataM : cap_data_p0;
        idx       = acc_addr[AW+1:2];
        bad       = is_illegal(acc_rd, acc_wr, acc_addr);
        done      = req && !reset && (cnt == WAIT_N);
        rd_val    = bad ? 32'h0 : mem[idx];
        StallM    = req && !reset && (cnt != WAIT_N);
        ErrM      = done && bad;
        ReadDataM = (done && acc_rd) ? rd_val : rd_q;
    end

    // p0: request capture on the first cycle of an access
    always_ff @(posedge clk) begin
        if (cnt == 4'd0 && req) begin
            cap_rd_p0   <= MemReadM;
            cap_wr_p0   <= MemWriteM;
            cap_addr_p0 <= ALUOutM;
            cap_data_p0 <= WriteDataM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            rd_q      <= 32'h0;
            ErrSticky <= 1'b0;
        end else if (done) begin
            cnt <= 4'd0;
            if (acc_rd) rd_q <= rd_val;
            if (bad) ErrSticky <= 1'b1;
        end else if (req) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt <= 4'd0;
        end
    end

    // Array is not reset; a store only lands on a legal completion edge.
    always_ff @(posedge clk) begin
        if (!reset && done && acc_wr && !bad) mem[idx] <= acc_data;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance
// and a zero-wait instance, both checked against an array-based reference model.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr, rd0, wr0;
    logic [31:0] addr, wdata, addr0, wdata0;
    logic [31:0] rdata, rdata0;
    logic        stall, err, sticky, stall0, err0, sticky0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .MemReadM(rd), .MemWriteM(wr), .ALUOutM(addr),
        .WriteDataM(wdata), .ReadDataM(rdata), .StallM(stall), .ErrM(err), .ErrSticky(sticky)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .MemReadM(rd0), .MemWriteM(wr0), .ALUOutM(addr0),
        .WriteDataM(wdata0), .ReadDataM(rdata0), .StallM(stall0), .ErrM(err0), .ErrSticky(sticky0)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_mem0 [4];
    logic [31:0] ref_rd, ref_rd0;
    bit          ref_sticky, ref_sticky0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit illegal(input logic r, input logic w, input logic [31:0] a);
        return (r && w) || (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full access on the waited instance; inputs may be scrambled after the first cycle.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit chg, input logic [31:0] a2, input logic [31:0] d2);
        bit          ill;
        logic [31:0] exp;
        rd = r; wr = w; addr = a; wdata = d;
        ill = illegal(r, w, a);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("stall_wait", stall, 1);
            chk("err_wait", err, 0);
            tick();
            if (chg) begin addr = a2; wdata = d2; end
        end
        @(negedge clk);
        chk("stall_done", stall, 0);
        chk("err_done", err, 32'(ill));
        if (r) begin
            exp = ill ? 32'h0 : ref_mem[a[7:2]];
            chk("rdata_done", rdata, exp);
            ref_rd = exp;
        end else begin
            chk("rdata_store", rdata, ref_rd);
        end
        if (w && !ill) ref_mem[a[7:2]] = d;
        if (ill) ref_sticky = 1'b1;
        tick();
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("rdata_hold", rdata, ref_rd);
        chk("sticky", sticky, 32'(ref_sticky));
        chk("stall_idle", stall, 0);
        tick();
    endtask

    task automatic abort_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd = r; wr = w; addr = a; wdata = d;
        @(negedge clk);
        chk("abort_stall", stall, 1);
        tick();
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("abort_idle", stall, 0);
        chk("abort_err", err, 0);
        chk("abort_rdata", rdata, ref_rd);
        tick();
    endtask

    // Zero-wait instance: every request cycle is its own completion cycle.
    task automatic access0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit          ill;
        logic [31:0] exp;
        rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
        ill = illegal(r, w, a);
        @(negedge clk);
        chk("z_stall", stall0, 0);
        chk("z_err", err0, 32'(ill));
        if (r) begin
            exp = ill ? 32'h0 : ref_mem0[a[3:2]];
            chk("z_rdata", rdata0, exp);
            ref_rd0 = exp;
        end else begin
            chk("z_rdata_store", rdata0, ref_rd0);
        end
        if (w && !ill) ref_mem0[a[3:2]] = d;
        if (ill) ref_sticky0 = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] a, d, a2, d2;
        int          op, v;
        reset = 1'b1;
        rd = 0; wr = 0; addr = 0; wdata = 0;
        rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        ref_rd = 0; ref_rd0 = 0; ref_sticky = 0; ref_sticky0 = 0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_rdata0", rdata0, 0);
        tick();

        for (int i = 0; i < DEPTH; i++)
            access(1'b0, 1'b1, 32'(i) << 2, $urandom, 1'b0, 32'h0, 32'h0);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0);

        access(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b1, 32'h24, 32'h22222222);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0, 32'h0);

        access(1'b0, 1'b1, 32'h13, 32'hBAD0BAD0, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b1, 32'h0, 32'hBAD1BAD1, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0);

        abort_access(1'b0, 1'b1, 32'h8, 32'h77777777);
        access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, 32'h0);

        // Reset landing in the second stall cycle of a store
        rd = 1'b0; wr = 1'b1; addr = 32'h4; wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rmid_stall", stall, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("rmid_stall_rst", stall, 0);
        chk("rmid_rdata_rst", rdata, 0);
        chk("rmid_sticky_rst", sticky, 0);
        ref_rd = 0; ref_sticky = 0; ref_rd0 = 0; ref_sticky0 = 0;
        tick();
        reset = 1'b0;
        access(1'b0, 1'b1, 32'h4, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
            d  = $urandom;
            a2 = $urandom;
            d2 = $urandom;
            if (op <= 3) begin
                access(1'b0, 1'b1, a, d, $urandom_range(0, 1) == 1, a2, d2);
            end else if (op <= 6) begin
                access(1'b1, 1'b0, a, d, $urandom_range(0, 1) == 1, a2, d2);
            end else if (op == 7) begin
                v = $urandom_range(0, 2);
                if (v == 0)      access($urandom_range(0, 1) == 1, 1'b1, a | 32'($urandom_range(1, 3)), d, 1'b0, a2, d2);
                else if (v == 1) access(1'b1, 1'b0, (32'(DEPTH) + 32'($urandom_range(0, 1000))) << 2, d, 1'b0, a2, d2);
                else             access(1'b1, 1'b1, a, d, 1'b0, a2, d2);
            end else begin
                abort_access($urandom_range(0, 1) == 1, 1'b1, a, d);
            end
        end

        access0(1'b0, 1'b1, 32'h0, 32'h5);
        access0(1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 1; i < 4; i++) access0(1'b0, 1'b1, 32'(i) << 2, $urandom);
        for (int n = 0; n < 30; n++) begin
            a = 32'($urandom_range(0, 3)) << 2;
            op = $urandom_range(0, 4);
            if (op <= 1)      access0(1'b0, 1'b1, a, $urandom);
            else if (op <= 3) access0(1'b1, 1'b0, a, 32'h0);
            else              access0(1'b1, 1'b0, a | 32'h2, 32'h0);
        end
        rd0 = 1'b0; wr0 = 1'b0;
        @(negedge clk);
        chk("z_hold", rdata0, ref_rd0);
        chk("z_sticky", sticky0, 32'(ref_sticky0));
        tick();

        for (int i = 0; i < DEPTH; i++)
            access(1'b1, 1'b0, 32'(i) << 2, 32'h0, 1'b0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
